// File: rtl/axis_burst_buffer.sv
// axis_burst_buffer
//
// Per-lane buffer between the lane splitter and the DMA fabric. Stores a
// valid-only 32-bit input stream in a first-word-fall-through FIFO and
// re-emits it as a backpressured AXI4-Stream in fixed-length bursts framed
// with TLAST. Words arriving while the FIFO is full are dropped and counted.
//
// Optional feature: define AXIS_BURST_BUFFER_FLUSH_EN to let 'flush' drain a
// partial burst while idle. Without the macro, 'flush' is ignored.
//
// Parameters:
//   DEPTH      FIFO depth in words (power of two, 4..1024)
//   BURST_LEN  words per burst (2..DEPTH)
//
// Ports:
//   clk40           sole clock
//   rstb            asynchronous active-low reset
//   S_AXIS_TDATA    input word
//   S_AXIS_TVALID   input valid (source never stalls)
//   M_AXIS_TDATA    output word, 0 while M_AXIS_TVALID is low
//   M_AXIS_TVALID   output valid
//   M_AXIS_TREADY   downstream ready
//   M_AXIS_TLAST    last word of a burst
//   flush           level request to drain a partial burst
//   fill_level      words stored and not yet accepted downstream
//   overflow_count  saturating count of dropped input words
`timescale 1ns/1ps

module axis_burst_buffer #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned BURST_LEN = 16
) (
    input  logic                   clk40,
    input  logic                   rstb,
    input  logic [31:0]            S_AXIS_TDATA,
    input  logic                   S_AXIS_TVALID,
    output logic [31:0]            M_AXIS_TDATA,
    output logic                   M_AXIS_TVALID,
    input  logic                   M_AXIS_TREADY,
    output logic                   M_AXIS_TLAST,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic [15:0]            overflow_count
);

    localparam int unsigned        AddrW     = $clog2(DEPTH);
    localparam logic [AddrW:0]     FillFull  = (AddrW+1)'(DEPTH);
    localparam logic [AddrW:0]     FillBurst = (AddrW+1)'(BURST_LEN);
    localparam logic [AddrW:0]     FillOne   = (AddrW+1)'(1);
    localparam logic [AddrW:0]     FillTwo   = (AddrW+1)'(2);
    localparam logic [AddrW-1:0]   PtrOne    = AddrW'(1);

    typedef enum logic {StIdle, StBurst} state_e;

    state_e            state_q;
    logic              valid_q;
    logic              last_q;
    logic [AddrW:0]    beat_q;
    logic [AddrW:0]    blen_q;
    logic [AddrW:0]    fill_q;
    logic [AddrW-1:0]  wr_ptr_q;
    logic [AddrW-1:0]  rd_ptr_q;
    logic [15:0]       ovf_q;
    logic [31:0]       mem [DEPTH];

    logic wr_en;
    logic rd_en;
    logic drop;

    // Full check uses the registered level, so a same-cycle read never frees
    // room for the incoming word.
    always_comb begin
        wr_en = S_AXIS_TVALID && (fill_q != FillFull);
        drop  = S_AXIS_TVALID && (fill_q == FillFull);
        rd_en = valid_q && M_AXIS_TREADY;
    end

    always_ff @(posedge clk40) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= S_AXIS_TDATA;
        end
    end

    always_ff @(posedge clk40 or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ovf_q    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            if (wr_en && !rd_en) begin
                fill_q <= fill_q + FillOne;
            end else if (!wr_en && rd_en) begin
                fill_q <= fill_q - FillOne;
            end
            if (drop && (ovf_q != 16'hFFFF)) begin
                ovf_q <= ovf_q + 16'd1;
            end
        end
    end

    // Burst framing. A burst only starts once all its words are stored, so
    // TVALID can stay high for the whole burst. The idle cycle after TLAST is
    // inherent: the start condition is only evaluated in StIdle.
    always_ff @(posedge clk40 or negedge rstb) begin
        if (!rstb) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            beat_q  <= '0;
            blen_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fill_q >= FillBurst) begin
                        state_q <= StBurst;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        beat_q  <= '0;
                        blen_q  <= FillBurst;
                    end
`ifdef AXIS_BURST_BUFFER_FLUSH_EN
                    else if (flush && (fill_q != '0)) begin
                        state_q <= StBurst;
                        valid_q <= 1'b1;
                        last_q  <= (fill_q == FillOne);
                        beat_q  <= '0;
                        blen_q  <= fill_q;
                    end
`endif
                end
                StBurst: begin
                    if (rd_en) begin
                        if (last_q) begin
                            state_q <= StIdle;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            beat_q <= beat_q + FillOne;
                            // Next beat is last when beat_q+1 == blen_q-1.
                            last_q <= ((beat_q + FillTwo) == blen_q);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

`ifndef AXIS_BURST_BUFFER_FLUSH_EN
    logic unused_flush;
    assign unused_flush = flush;
`endif

    assign M_AXIS_TVALID  = valid_q;
    assign M_AXIS_TLAST   = last_q;
    assign M_AXIS_TDATA   = valid_q ? mem[rd_ptr_q] : 32'd0;
    assign fill_level     = fill_q;
    assign overflow_count = ovf_q;

endmodule

// File: tb/tb_axis_burst_buffer.sv
`timescale 1ns/1ps

module tb_axis_burst_buffer;

    localparam int unsigned DEPTH     = 64;
    localparam int unsigned BURST_LEN = 16;

    logic        clk40 = 1'b0;
    logic        rstb  = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic        flush = 1'b0;
    logic [6:0]  fill_level;
    logic [15:0] overflow_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #12 clk40 = ~clk40;

    axis_burst_buffer #(
        .DEPTH     (DEPTH),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk40          (clk40),
        .rstb           (rstb),
        .S_AXIS_TDATA   (s_tdata),
        .S_AXIS_TVALID  (s_tvalid),
        .M_AXIS_TDATA   (m_tdata),
        .M_AXIS_TVALID  (m_tvalid),
        .M_AXIS_TREADY  (m_tready),
        .M_AXIS_TLAST   (m_tlast),
        .flush          (flush),
        .fill_level     (fill_level),
        .overflow_count (overflow_count)
    );

    // Reference model: a queue of stored words plus "words left in the
    // current burst". Updated on each clock edge from the inputs presented
    // before that edge.
    logic [31:0] mq[$];
    int          m_ovf;
    bit          m_burst;
    int          m_total;
    int          m_beat;
    int          m_size0;

    always @(posedge clk40 or negedge rstb) begin
        if (!rstb) begin
            mq.delete();
            m_ovf   = 0;
            m_burst = 0;
            m_total = 0;
            m_beat  = 0;
        end else begin
            m_size0 = mq.size();
            if (m_burst) begin
                if (m_tready) begin
                    void'(mq.pop_front());
                    if (m_beat == m_total - 1) m_burst = 0;
                    else m_beat++;
                end
            end else if (m_size0 >= BURST_LEN) begin
                m_burst = 1;
                m_total = BURST_LEN;
                m_beat  = 0;
            end
`ifdef AXIS_BURST_BUFFER_FLUSH_EN
            else if (flush && m_size0 > 0) begin
                m_burst = 1;
                m_total = m_size0;
                m_beat  = 0;
            end
`endif
            if (s_tvalid) begin
                if (m_size0 < DEPTH) mq.push_back(s_tdata);
                else if (m_ovf < 65535) m_ovf++;
            end
        end
    end

    task automatic apply_reset();
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;
        flush    = 1'b0;
        @(negedge clk40);
        rstb = 1'b0;
        repeat (2) @(negedge clk40);
        rstb = 1'b1;
    endtask

    task automatic write_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk40); #1;
            s_tvalid = 1'b1;
            s_tdata  = base + 32'(i);
        end
        @(posedge clk40); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %0b want 0", m_tvalid); end
        n_tests++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %0b want 0", m_tlast); end
        n_tests++; if (m_tdata !== 32'd0) begin n_fail++; $display("FAIL reset_tdata: got %0h want 0", m_tdata); end
        n_tests++; if (fill_level !== 7'd0) begin n_fail++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
        n_tests++; if (overflow_count !== 16'd0) begin n_fail++; $display("FAIL reset_ovf: got %0d want 0", overflow_count); end
    endtask

    task automatic test_single_burst();
        int nb;
        apply_reset();
        m_tready = 1'b1;
        write_words(32'h0, 16);
        @(negedge clk40);
        n_tests++; if (fill_level !== 7'd16) begin n_fail++; $display("FAIL single_fill16: got %0d want 16", fill_level); end
        n_tests++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %0b want 0", m_tvalid); end
        nb = 0;
        for (int c = 0; c < 40 && nb < 16; c++) begin
            @(negedge clk40);
            if (c == 0) begin
                n_tests++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL single_latency: got %0b want 1", m_tvalid); end
            end
            if (m_tvalid) begin
                n_tests++; if (m_tdata !== 32'(nb)) begin n_fail++; $display("FAIL single_data[%0d]: got %0h want %0h", nb, m_tdata, nb); end
                n_tests++; if (m_tlast !== (nb == 15)) begin n_fail++; $display("FAIL single_last[%0d]: got %0b want %0b", nb, m_tlast, nb == 15); end
                nb++;
            end
        end
        n_tests++; if (nb != 16) begin n_fail++; $display("FAIL single_beats: got %0d want 16", nb); end
        @(negedge clk40);
        n_tests++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_idle_after: got %0b want 0", m_tvalid); end
        n_tests++; if (fill_level !== 7'd0) begin n_fail++; $display("FAIL single_fill_end: got %0d want 0", fill_level); end
    endtask

    task automatic test_backpressure();
        int nb;
        int nlast;
        logic [31:0] base;
        apply_reset();
        base  = $urandom;
        nb    = 0;
        nlast = 0;
        for (int c = 0; c < 100 && nb < 16; c++) begin
            @(posedge clk40); #1;
            s_tvalid = (c < 16);
            s_tdata  = base + 32'(c);
            m_tready = (c % 2 == 0);
            @(negedge clk40);
            if (m_tvalid) begin
                // Checked on stalled cycles too: the word must be held.
                n_tests++; if (m_tdata !== base + 32'(nb)) begin n_fail++; $display("FAIL bp_data[%0d]: got %0h want %0h", nb, m_tdata, base + 32'(nb)); end
                n_tests++; if (m_tlast !== (nb == 15)) begin n_fail++; $display("FAIL bp_last[%0d]: got %0b want %0b", nb, m_tlast, nb == 15); end
                if (m_tready) begin
                    if (m_tlast) nlast++;
                    nb++;
                end
            end
        end
        s_tvalid = 1'b0;
        n_tests++; if (nb != 16) begin n_fail++; $display("FAIL bp_beats: got %0d want 16", nb); end
        n_tests++; if (nlast != 1) begin n_fail++; $display("FAIL bp_tlast_count: got %0d want 1", nlast); end
        @(negedge clk40);
        n_tests++; if (fill_level !== 7'd0) begin n_fail++; $display("FAIL bp_fill_end: got %0d want 0", fill_level); end
        n_tests++; if (overflow_count !== 16'd0) begin n_fail++; $display("FAIL bp_ovf: got %0d want 0", overflow_count); end
    endtask

    task automatic test_overflow();
        int nb;
        apply_reset();
        write_words(32'h1000, 70);
        @(negedge clk40);
        n_tests++; if (fill_level !== 7'd64) begin n_fail++; $display("FAIL ovf_fill: got %0d want 64", fill_level); end
        n_tests++; if (overflow_count !== 16'd6) begin n_fail++; $display("FAIL ovf_count: got %0d want 6", overflow_count); end
        n_tests++; if (m_tdata !== 32'h1000) begin n_fail++; $display("FAIL ovf_first_word: got %0h want 1000", m_tdata); end
        @(posedge clk40); #1;
        m_tready = 1'b1;
        nb = 0;
        for (int c = 0; c < 200 && nb < 64; c++) begin
            @(negedge clk40);
            if (m_tvalid) begin
                n_tests++; if (m_tdata !== 32'h1000 + 32'(nb)) begin n_fail++; $display("FAIL ovf_data[%0d]: got %0h want %0h", nb, m_tdata, 32'h1000 + 32'(nb)); end
                n_tests++; if (m_tlast !== (nb % 16 == 15)) begin n_fail++; $display("FAIL ovf_last[%0d]: got %0b want %0b", nb, m_tlast, nb % 16 == 15); end
                nb++;
            end
        end
        n_tests++; if (nb != 64) begin n_fail++; $display("FAIL ovf_beats: got %0d want 64", nb); end
        repeat (3) @(negedge clk40);
        n_tests++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL ovf_no_extra: got %0b want 0", m_tvalid); end
        n_tests++; if (fill_level !== 7'd0) begin n_fail++; $display("FAIL ovf_fill_end: got %0d want 0", fill_level); end
    endtask

    task automatic test_full_simul();
        apply_reset();
        write_words(32'h2000, 64);
        // Write and read in the same cycle while full.
        s_tvalid = 1'b1;
        s_tdata  = 32'hDEAD_BEEF;
        m_tready = 1'b1;
        @(posedge clk40); #1;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        @(negedge clk40);
        n_tests++; if (fill_level !== 7'd63) begin n_fail++; $display("FAIL full_rw_fill: got %0d want 63", fill_level); end
        n_tests++; if (overflow_count !== 16'd1) begin n_fail++; $display("FAIL full_rw_ovf: got %0d want 1", overflow_count); end
        n_tests++; if (m_tdata !== 32'h2001) begin n_fail++; $display("FAIL full_rw_next: got %0h want 2001", m_tdata); end
    endtask

    task automatic test_flush();
        int nb;
        apply_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk40); #1;
            s_tvalid = 1'b1;
            s_tdata  = 32'hA0 + 32'(i);
        end
        @(posedge clk40); #1;
        s_tvalid = 1'b0;
        flush    = 1'b1;
        @(posedge clk40); #1;
        flush = 1'b0;
        nb = 0;
`ifdef AXIS_BURST_BUFFER_FLUSH_EN
        for (int c = 0; c < 30 && nb < 5; c++) begin
            @(negedge clk40);
            if (m_tvalid) begin
                n_tests++; if (m_tdata !== 32'hA0 + 32'(nb)) begin n_fail++; $display("FAIL flush_data[%0d]: got %0h want %0h", nb, m_tdata, 32'hA0 + 32'(nb)); end
                n_tests++; if (m_tlast !== (nb == 4)) begin n_fail++; $display("FAIL flush_last[%0d]: got %0b want %0b", nb, m_tlast, nb == 4); end
                nb++;
            end
        end
        n_tests++; if (nb != 5) begin n_fail++; $display("FAIL flush_beats: got %0d want 5", nb); end
        @(negedge clk40);
        n_tests++; if (fill_level !== 7'd0) begin n_fail++; $display("FAIL flush_fill_end: got %0d want 0", fill_level); end
`else
        for (int c = 0; c < 12; c++) begin
            @(negedge clk40);
            if (m_tvalid) nb++;
        end
        n_tests++; if (nb != 0) begin n_fail++; $display("FAIL noflush_quiet: got %0d beats want 0", nb); end
        n_tests++; if (fill_level !== 7'd5) begin n_fail++; $display("FAIL noflush_fill: got %0d want 5", fill_level); end
        write_words(32'hA5, 11);
        nb = 0;
        for (int c = 0; c < 40 && nb < 16; c++) begin
            @(negedge clk40);
            if (m_tvalid) begin
                n_tests++; if (m_tdata !== 32'hA0 + 32'(nb)) begin n_fail++; $display("FAIL noflush_data[%0d]: got %0h want %0h", nb, m_tdata, 32'hA0 + 32'(nb)); end
                n_tests++; if (m_tlast !== (nb == 15)) begin n_fail++; $display("FAIL noflush_last[%0d]: got %0b want %0b", nb, m_tlast, nb == 15); end
                nb++;
            end
        end
        n_tests++; if (nb != 16) begin n_fail++; $display("FAIL noflush_beats: got %0d want 16", nb); end
`endif
    endtask

    task automatic test_reset_mid_burst();
        int nb;
        bit hit;
        apply_reset();
        m_tready = 1'b1;
        write_words(32'h3000, 16);
        nb  = 0;
        hit = 0;
        for (int c = 0; c < 60 && !hit; c++) begin
            @(negedge clk40);
            if (m_tvalid) begin
                if (nb == 7) hit = 1;
                else nb++;
            end
        end
        n_tests++; if (!hit) begin n_fail++; $display("FAIL midrst_reach_beat7: got %0d beats want 7", nb); end
        rstb = 1'b0;
        #1;
        n_tests++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_tvalid: got %0b want 0", m_tvalid); end
        n_tests++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL midrst_tlast: got %0b want 0", m_tlast); end
        n_tests++; if (fill_level !== 7'd0) begin n_fail++; $display("FAIL midrst_fill: got %0d want 0", fill_level); end
        @(negedge clk40);
        rstb = 1'b1;
        write_words(32'h4000, 16);
        nb = 0;
        for (int c = 0; c < 40 && nb < 16; c++) begin
            @(negedge clk40);
            if (m_tvalid) begin
                n_tests++; if (m_tdata !== 32'h4000 + 32'(nb)) begin n_fail++; $display("FAIL midrst_data[%0d]: got %0h want %0h", nb, m_tdata, 32'h4000 + 32'(nb)); end
                n_tests++; if (m_tlast !== (nb == 15)) begin n_fail++; $display("FAIL midrst_last[%0d]: got %0b want %0b", nb, m_tlast, nb == 15); end
                nb++;
            end
        end
        n_tests++; if (nb != 16) begin n_fail++; $display("FAIL midrst_beats: got %0d want 16", nb); end
    endtask

    task automatic test_random();
        logic [31:0] exp_data;
        bit          exp_last;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk40); #1;
            s_tvalid = ($urandom_range(99) < 60);
            s_tdata  = $urandom;
            m_tready = (c < 800) ? ($urandom_range(99) < 25) : ($urandom_range(99) < 75);
            flush    = ($urandom_range(99) < 8);
            @(negedge clk40);
            exp_data = m_burst ? mq[0] : 32'd0;
            exp_last = m_burst && (m_beat == m_total - 1);
            n_tests++; if (m_tvalid !== m_burst) begin n_fail++; $display("FAIL rnd_valid @%0d: got %0b want %0b", c, m_tvalid, m_burst); end
            n_tests++; if (m_tlast !== exp_last) begin n_fail++; $display("FAIL rnd_last @%0d: got %0b want %0b", c, m_tlast, exp_last); end
            n_tests++; if (m_tdata !== exp_data) begin n_fail++; $display("FAIL rnd_data @%0d: got %0h want %0h", c, m_tdata, exp_data); end
            n_tests++; if (fill_level !== 7'(mq.size())) begin n_fail++; $display("FAIL rnd_fill @%0d: got %0d want %0d", c, fill_level, mq.size()); end
            n_tests++; if (overflow_count !== 16'(m_ovf)) begin n_fail++; $display("FAIL rnd_ovf @%0d: got %0d want %0d", c, overflow_count, m_ovf); end
        end
        s_tvalid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_backpressure();
        test_overflow();
        test_full_simul();
        test_flush();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
